// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package : regfile_pkg
// Brief   : Shared constants and types for the parametrised register file.
// Rev     : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 6;
  localparam int ZERO_ADDR  = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module : regfile_rdport
// Brief  : One registered read port: write-through/zero-register mux feeding
//          an output register that holds its value while ren_i is low.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W      = REG_DATA_W,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter bit ZERO_REG_EN = 1'b0,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] fwd_data;
  logic              addr_is_zero;

  // wr_en_i is already qualified by the top, so a dropped write never forwards
  generate
    if (BYPASS_EN) begin : g_bypass
      assign fwd_data = (wr_en_i && (wr_addr_i == addr_i)) ? wr_data_i : mem_data_i;
    end else begin : g_no_bypass
      assign fwd_data = mem_data_i;
    end
  endgenerate

  generate
    if (ZERO_REG_EN) begin : g_zero
      localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);
      assign addr_is_zero = (addr_i == ZERO_A);
    end else begin : g_no_zero
      assign addr_is_zero = 1'b0;
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (ren_i) begin
      data_d = addr_is_zero ? '0 : fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module : regfile_param
// Brief  : Parametrised 2-read/1-write register file with synchronous clear,
//          optional zero register, write-through bypass and read stall.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W      = REG_DATA_W,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter bit ZERO_REG_EN = 1'b0,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] din,
  input  logic              wrt,
  input  logic              ren,
  output logic [DATA_W-1:0] sout,
  output logic [DATA_W-1:0] tout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  generate
    if (ZERO_REG_EN) begin : g_zero_drop
      localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);
      assign wr_en = wrt && (rd != ZERO_A);
    end else begin : g_no_zero_drop
      assign wr_en = wrt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[rd] <= din;
    end
  end

  regfile_rdport #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN),
    .BYPASS_EN   (BYPASS_EN)
  ) u_port_s (
    .clk        (clk),
    .rst        (rst),
    .ren_i      (ren),
    .addr_i     (rs),
    .mem_data_i (mem_q[rs]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (rd),
    .wr_data_i  (din),
    .data_o     (sout)
  );

  regfile_rdport #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN),
    .BYPASS_EN   (BYPASS_EN)
  ) u_port_t (
    .clk        (clk),
    .rst        (rst),
    .ren_i      (ren),
    .addr_i     (rt),
    .mem_data_i (mem_q[rt]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (rd),
    .wr_data_i  (din),
    .data_o     (tout)
  );

endmodule : regfile_param
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_param
// Brief  : Directed bench for regfile_param: default, zero-reg/no-bypass and
//          narrow/shallow configurations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  // shared stimulus for the two 32x64 instances
  logic [5:0]  rs, rt, rd;
  logic [31:0] din;
  logic        wrt, ren;
  logic [31:0] sout_a, tout_a, sout_b, tout_b;
  // stimulus for the 16x8 instance
  logic [2:0]  c_rs, c_rt, c_rd;
  logic [15:0] c_din;
  logic        c_wrt, c_ren;
  logic [15:0] sout_c, tout_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // bypass on, no zero register
  regfile_param #(.DATA_W(32), .ADDR_W(6), .ZERO_REG_EN(1'b0), .BYPASS_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .din(din),
    .wrt(wrt), .ren(ren), .sout(sout_a), .tout(tout_a)
  );

  // zero register on, bypass off
  regfile_param #(.DATA_W(32), .ADDR_W(6), .ZERO_REG_EN(1'b1), .BYPASS_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .din(din),
    .wrt(wrt), .ren(ren), .sout(sout_b), .tout(tout_b)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG_EN(1'b0), .BYPASS_EN(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .rs(c_rs), .rt(c_rt), .rd(c_rd), .din(c_din),
    .wrt(c_wrt), .ren(c_ren), .sout(sout_c), .tout(tout_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle 1ns so registered outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; rd = '0; din = '0; wrt = 1'b0; ren = 1'b0;
    c_rs = '0; c_rt = '0; c_rd = '0; c_din = '0; c_wrt = 1'b0; c_ren = 1'b0;
    tick();
    check("rst_sout_a", sout_a, 32'h0);
    check("rst_tout_a", tout_a, 32'h0);
    check("rst_sout_b", sout_b, 32'h0);
    check("rst_tout_b", tout_b, 32'h0);
    check("rst_sout_c", 32'(sout_c), 32'h0);
    rst = 1'b0;

    // reset clears storage
    wrt = 1'b1; rd = 6'd5; din = 32'hDEADBEEF;
    tick();
    wrt = 1'b0; rs = 6'd5; rt = 6'd5; ren = 1'b1;
    tick();
    check("pre_rst_mem5", sout_a, 32'hDEADBEEF);
    rst = 1'b1; ren = 1'b0;
    tick();
    rst = 1'b0; ren = 1'b1;
    tick();
    check("clr_sout_a", sout_a, 32'h0);
    check("clr_tout_a", tout_a, 32'h0);
    check("clr_sout_b", sout_b, 32'h0);

    // write during reset is lost
    rst = 1'b1; wrt = 1'b1; rd = 6'd9; din = 32'h55;
    tick();
    rst = 1'b0; wrt = 1'b0; rs = 6'd9; rt = 6'd9;
    tick();
    check("rst_write_lost", sout_a, 32'h0);

    // one-cycle latency
    wrt = 1'b1; rd = 6'd3; din = 32'd5; rs = 6'd0; rt = 6'd0;
    tick();
    wrt = 1'b0; rs = 6'd3;
    #2;
    check("lat_hold_before", sout_a, 32'h0);
    tick();
    check("lat_sout_a", sout_a, 32'd5);
    check("lat_sout_b", sout_b, 32'd5);

    // bypass vs no-bypass
    wrt = 1'b1; rd = 6'd7; din = 32'h77; ren = 1'b0;
    tick();
    din = 32'h1234; rs = 6'd7; rt = 6'd7; ren = 1'b1;
    tick();
    check("byp_sout_a", sout_a, 32'h1234);
    check("byp_tout_a", tout_a, 32'h1234);
    check("nobyp_sout_b", sout_b, 32'h77);
    check("nobyp_tout_b", tout_b, 32'h77);
    wrt = 1'b0;
    tick();
    check("nobyp_after_b", sout_b, 32'h1234);

    // ports read different addresses
    rs = 6'd3; rt = 6'd7;
    tick();
    check("dual_sout_a", sout_a, 32'd5);
    check("dual_tout_a", tout_a, 32'h1234);

    // top address
    wrt = 1'b1; rd = 6'd63; din = 32'h3F3F3F3F; rs = 6'd63; rt = 6'd0; ren = 1'b0;
    tick();
    wrt = 1'b0; ren = 1'b1;
    tick();
    check("addr63_sout_a", sout_a, 32'h3F3F3F3F);
    check("addr63_tout_b", tout_b, 32'h0);

    // zero register: B drops the write, A stores it
    wrt = 1'b1; rd = 6'd0; din = 32'hFFFFFFFF; rs = 6'd0; rt = 6'd0;
    tick();
    check("zero_sout_b", sout_b, 32'h0);
    check("zero_tout_b", tout_b, 32'h0);
    check("zero_byp_a", sout_a, 32'hFFFFFFFF);
    wrt = 1'b0;
    tick();
    check("zero_later_b", sout_b, 32'h0);
    check("zero_later_a", sout_a, 32'hFFFFFFFF);

    // stall
    wrt = 1'b1; rd = 6'd2; din = 32'hA; ren = 1'b0;
    tick();
    wrt = 1'b0; rs = 6'd2; ren = 1'b1;
    tick();
    check("stall_pre_a", sout_a, 32'hA);
    ren = 1'b0; wrt = 1'b1; rd = 6'd2; din = 32'hB; rs = 6'd4;
    tick();
    check("stall1_a", sout_a, 32'hA);
    check("stall1_b", sout_b, 32'hA);
    wrt = 1'b0; rs = 6'd5;
    tick();
    check("stall2_a", sout_a, 32'hA);
    rs = 6'd2;
    tick();
    check("stall3_a", sout_a, 32'hA);
    ren = 1'b1;
    tick();
    check("stall_rel_a", sout_a, 32'hB);
    check("stall_rel_b", sout_b, 32'hB);
    ren = 1'b0;

    // narrow/shallow sweep
    c_wrt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_rd = 3'(i); c_din = 16'(i * 16'h1111);
      tick();
    end
    c_wrt = 1'b0; c_ren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_rs = 3'(i); c_rt = 3'(7 - i);
      tick();
      check($sformatf("sweep_s%0d", i), 32'(sout_c), 32'(16'(i * 16'h1111)));
      check($sformatf("sweep_t%0d", 7 - i), 32'(tout_c), 32'(16'((7 - i) * 16'h1111)));
    end
    c_wrt = 1'b1; c_rd = 3'd7; c_din = 16'hABCD; c_ren = 1'b0;
    tick();
    c_wrt = 1'b0; c_rs = 3'd0; c_rt = 3'd7; c_ren = 1'b1;
    tick();
    check("alias_s0", 32'(sout_c), 32'h0);
    check("alias_t7", 32'(tout_c), 32'hABCD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_param
`default_nettype wire
